// File: rtl/ddr4_avmm_responder_if.sv
// Avalon-MM burst port between the BIST AFU DDR4 master and the on-chip responder.
interface ddr4_avmm_responder_if #(
    parameter int unsigned ADDR_WIDTH  = 27,
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned BURST_WIDTH = 7
);
    logic                      avs_waitrequest;
    logic [DATA_WIDTH-1:0]     avs_readdata;
    logic                      avs_readdatavalid;
    logic [BURST_WIDTH-1:0]    avs_burstcount;
    logic [DATA_WIDTH-1:0]     avs_writedata;
    logic [ADDR_WIDTH-1:0]     avs_address;
    logic                      avs_write;
    logic                      avs_read;
    logic [DATA_WIDTH/8-1:0]   avs_byteenable;

    modport master (
        input  avs_waitrequest, avs_readdata, avs_readdatavalid,
        output avs_burstcount, avs_writedata, avs_address, avs_write, avs_read, avs_byteenable
    );

    modport slave (
        output avs_waitrequest, avs_readdata, avs_readdatavalid,
        input  avs_burstcount, avs_writedata, avs_address, avs_write, avs_read, avs_byteenable
    );
endinterface

// File: rtl/ddr4_avmm_responder.sv
// Avalon-MM burst slave backed by an on-chip memory model, standing in for the DDR4 EMIF.
// Optional DDR4_RSP_WAIT_INJECT_EN adds LFSR-driven waitrequest stalls in IDLE/WR_BURST.
module ddr4_avmm_responder #(
    parameter int unsigned ADDR_WIDTH     = 27,
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned BURST_WIDTH    = 7,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned RD_LATENCY     = 4
) (
    input  logic                  Clk_400,
    input  logic                  SoftReset,
    ddr4_avmm_responder_if.slave  avs,
    output logic [31:0]           rd_beat_cnt,
    output logic [31:0]           wr_beat_cnt,
    output logic                  proto_err
);
    localparam int unsigned IDX_W  = MEM_DEPTH_LOG2;
    localparam int unsigned DEPTH  = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned BE_W   = DATA_WIDTH / 8;
    localparam int unsigned PIPE_D = RD_LATENCY - 1;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t                         state, state_nxt;
    logic [IDX_W-1:0]               base, base_nxt;
    logic [BURST_WIDTH-1:0]         offs, offs_nxt;
    logic [BURST_WIDTH-1:0]         remaining, remaining_nxt;
    logic                           waitreq, wait_nxt;
    logic                           wr_en_c, issue_c, err_set_c;
    logic [IDX_W-1:0]               addr_idx_c, beat_idx_c, wr_idx_c;
    logic [DATA_WIDTH-1:0]          wr_word_c;
    logic [DATA_WIDTH-1:0]          mem [DEPTH];
    logic [PIPE_D-1:0]              pipe_vld;
    logic [PIPE_D-1:0][IDX_W-1:0]   pipe_idx;
    logic                           rvalid;
    logic [DATA_WIDTH-1:0]          rdata;
    logic                           unused_addr_hi;

    assign addr_idx_c     = avs.avs_address[IDX_W-1:0];
    assign unused_addr_hi = ^avs.avs_address[ADDR_WIDTH-1:IDX_W];
    assign beat_idx_c     = base + IDX_W'(offs);

    assign avs.avs_waitrequest   = waitreq;
    assign avs.avs_readdatavalid = rvalid;
    assign avs.avs_readdata      = rdata;

`ifdef DDR4_RSP_WAIT_INJECT_EN
    logic [15:0] lfsr, lfsr_nxt;
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_ff @(posedge Clk_400 or posedge SoftReset) begin
        if (SoftReset) lfsr <= 16'hACE1;
        else           lfsr <= lfsr_nxt;
    end
`else
`endif

    // Next-state and command decode
    always_comb begin
        state_nxt     = state;
        base_nxt      = base;
        offs_nxt      = offs;
        remaining_nxt = remaining;
        wr_en_c       = 1'b0;
        wr_idx_c      = beat_idx_c;
        issue_c       = 1'b0;
        err_set_c     = 1'b0;
        case (state)
            IDLE: begin
                if (avs.avs_write && !waitreq) begin
                    err_set_c = avs.avs_read || (avs.avs_burstcount == '0);
                    if (avs.avs_burstcount != '0) begin
                        wr_en_c  = 1'b1;
                        wr_idx_c = addr_idx_c;
                        if (avs.avs_burstcount != BURST_WIDTH'(1)) begin
                            state_nxt     = WR_BURST;
                            base_nxt      = addr_idx_c;
                            offs_nxt      = BURST_WIDTH'(1);
                            remaining_nxt = avs.avs_burstcount - BURST_WIDTH'(1);
                        end
                    end
                end else if (avs.avs_read && !waitreq) begin
                    if (avs.avs_burstcount == '0) begin
                        err_set_c = 1'b1;
                    end else begin
                        state_nxt     = RD_BURST;
                        base_nxt      = addr_idx_c;
                        offs_nxt      = '0;
                        remaining_nxt = avs.avs_burstcount;
                    end
                end
            end
            WR_BURST: begin
                err_set_c = avs.avs_read;
                if (avs.avs_write && !waitreq) begin
                    wr_en_c       = 1'b1;
                    offs_nxt      = offs + BURST_WIDTH'(1);
                    remaining_nxt = remaining - BURST_WIDTH'(1);
                    if (remaining == BURST_WIDTH'(1)) state_nxt = IDLE;
                end
            end
            RD_BURST: begin
                issue_c       = 1'b1;
                offs_nxt      = offs + BURST_WIDTH'(1);
                remaining_nxt = remaining - BURST_WIDTH'(1);
                if (remaining == BURST_WIDTH'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`ifdef DDR4_RSP_WAIT_INJECT_EN
        wait_nxt = (state_nxt == RD_BURST) || (lfsr_nxt[1:0] == 2'b00);
`else
        wait_nxt = (state_nxt == RD_BURST);
`endif
    end

    always_ff @(posedge Clk_400 or posedge SoftReset) begin
        if (SoftReset) begin
            state       <= IDLE;
            base        <= '0;
            offs        <= '0;
            remaining   <= '0;
            waitreq     <= 1'b1;
            proto_err   <= 1'b0;
            wr_beat_cnt <= '0;
        end else begin
            state     <= state_nxt;
            base      <= base_nxt;
            offs      <= offs_nxt;
            remaining <= remaining_nxt;
            waitreq   <= wait_nxt;
            proto_err <= proto_err | err_set_c;
            if (wr_en_c) wr_beat_cnt <= wr_beat_cnt + 32'd1;
        end
    end

    // Byte-enable merge against the current word
    always_comb begin
        wr_word_c = mem[wr_idx_c];
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (avs.avs_byteenable[b]) wr_word_c[8*b +: 8] = avs.avs_writedata[8*b +: 8];
        end
    end

    // Memory has no reset so contents survive SoftReset
    always_ff @(posedge Clk_400) begin
        if (wr_en_c) mem[wr_idx_c] <= wr_word_c;
    end

    // Read latency pipeline; the memory is sampled at the output stage
    always_ff @(posedge Clk_400 or posedge SoftReset) begin
        if (SoftReset) begin
            pipe_vld    <= '0;
            pipe_idx    <= '0;
            rvalid      <= 1'b0;
            rdata       <= '0;
            rd_beat_cnt <= '0;
        end else begin
            pipe_vld[0] <= issue_c;
            pipe_idx[0] <= beat_idx_c;
            for (int unsigned k = 1; k < PIPE_D; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_idx[k] <= pipe_idx[k-1];
            end
            rvalid <= pipe_vld[PIPE_D-1];
            if (pipe_vld[PIPE_D-1]) begin
                rdata       <= mem[pipe_idx[PIPE_D-1]];
                rd_beat_cnt <= rd_beat_cnt + 32'd1;
            end
        end
    end
endmodule

// File: doc/ddr4_avmm_responder.md
Name: ddr4_avmm_responder

Overview:
- Avalon-MM burst slave that terminates the DDR4 master port of the BIST loopback AFU (DDR4a/DDR4b bus shape).
- Backs the port with an on-chip memory model. Supports write and read bursts, byte enables and a fixed read latency.
- Used in SIM_MODE builds and in DDR-less BIST bring-up images, in place of the EMIF controller.
- Provides beat counters and a sticky protocol-error flag for bench checking.

Parameters:
- ADDR_WIDTH, 27: word address width; one word = DATA_WIDTH bits.
- DATA_WIDTH, 512: data bus width.
- BURST_WIDTH, 7: burstcount width; legal burst is 1..2^(BURST_WIDTH-1) = 64.
- MEM_DEPTH_LOG2, 10: log2 of model depth in words.
- RD_LATENCY, 4: cycles from read acceptance to first readdatavalid; must be >= 2.

Ports:
- Clk_400, in, 1: single clock, rising edge.
- SoftReset, in, 1: asynchronous, active-high reset.
- avs_waitrequest, out, 1: slave stall.
- avs_readdata, out, DATA_WIDTH: read beat data.
- avs_readdatavalid, out, 1: read beat valid; there is no backpressure on this signal.
- avs_burstcount, in, BURST_WIDTH: beats in the burst; sampled on the first beat only.
- avs_writedata, in, DATA_WIDTH: write beat data.
- avs_address, in, ADDR_WIDTH: burst start word address; sampled on the first beat only.
- avs_write, in, 1: write request / write beat.
- avs_read, in, 1: read command.
- avs_byteenable, in, DATA_WIDTH/8: per-beat byte enables for writes; ignored on reads.
- rd_beat_cnt, out, 32: read beats returned; wraps.
- wr_beat_cnt, out, 32: write beats committed; wraps.
- proto_err, out, 1: sticky protocol error flag.

Behaviour:
- Reset values: avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, counters=0, proto_err=0, FSM=IDLE, read pipeline valids cleared.
  - Memory contents are retained across reset and are undefined at power-up.
- Reset asserted mid-burst: the burst is aborted. Any remaining write beats are dropped and no further readdatavalid is produced. avs_waitrequest drops to 0 on the first edge after SoftReset deasserts.
- Memory index = (burst start address + beat offset) mod 2^MEM_DEPTH_LOG2. Upper address bits are ignored; the index wraps silently.
- A beat or command is accepted on an edge where the request is high and avs_waitrequest=0.
- FSM IDLE:
  - avs_write accepted: beat 0 is committed. If burstcount=1, stay in IDLE; otherwise go to WR_BURST with remaining = burstcount-1.
  - avs_read accepted: start address and burstcount are captured; go to RD_BURST.
  - avs_write and avs_read both high: write wins, read is ignored, proto_err is set.
  - Accepted burstcount=0: the command is dropped, no beats are committed or returned, proto_err is set, FSM stays in IDLE.
- FSM WR_BURST:
  - Each accepted beat commits writedata under byteenable. Bytes with byteenable=0 keep their old value. Each beat increments wr_beat_cnt.
  - The edge that commits the last beat returns the FSM to IDLE.
  - avs_read high in this state is ignored and sets proto_err.
  - avs_waitrequest=0 here, except when the optional feature asserts it.
- FSM RD_BURST:
  - avs_waitrequest=1.
  - One beat is issued into the RD_LATENCY-deep pipeline per cycle, with no gaps.
  - After the last beat is issued, the FSM returns to IDLE. The next command can be accepted on the following edge.
- Read timing: for a read accepted at edge N, beat i is presented with avs_readdatavalid=1 in the cycle after edge N+RD_LATENCY+i. Each beat increments rd_beat_cnt.
- Back-to-back reads: beats of consecutive bursts may be separated by a one-cycle bubble. Responses are always returned in order.
- Read-after-write: a read accepted after the last write beat commits returns the new data.
- When avs_readdatavalid=0, avs_readdata holds its last value.
- proto_err is cleared only by SoftReset.

Optional Feature:
- Macro: DDR4_RSP_WAIT_INJECT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on SoftReset) advances every cycle.
  - In IDLE and WR_BURST, avs_waitrequest is additionally forced to 1 whenever lfsr[1:0]==2'b00.
  - RD_BURST beat issue and read latency are unaffected.
- Undefined: no LFSR exists, and avs_waitrequest follows the FSM rules only.

Test Plan:
- Write burst address 0x10, burstcount 4, byteenable all-ones, data 0xA0..0xA3, then read burst address 0x10, burstcount 4 -> four readdatavalid beats, 0xA0..0xA3, first beat 4 cycles after read acceptance, contiguous; wr_beat_cnt=4, rd_beat_cnt=4.
- Single-beat write address 0x20 of all-ones, then single-beat write address 0x20 of zeros with byteenable=64'h0000_0000_0000_00FF, then read -> low 8 bytes 0x00, upper 56 bytes 0xFF.
- Write burst address 0x3FE, burstcount 4 (MEM_DEPTH_LOG2=10), then read burst address 0x3FE, burstcount 4 -> beats 2 and 3 come from indices 0x000 and 0x001; data matches the write order.
- avs_write and avs_read both high in IDLE, then burstcount=0 read -> only the write commits; proto_err=1 and stays 1; no readdatavalid for the zero-length read.
- SoftReset pulsed after 2 of 8 read beats are issued -> readdatavalid=0 from reset assertion onward; rd_beat_cnt=0; avs_waitrequest=1 during reset and 0 on the first edge after deassert; a subsequent read returns the correct data.
- With DDR4_RSP_WAIT_INJECT_EN, a 64-beat write then 64-beat read -> all data correct; waitrequest stalls observed during the write; read beats contiguous.
